// File: rtl/riscv_pipeline_fwd.sv
`default_nettype none
// ============================================================================
// | Module      : riscv_pipeline_fwd                                         |
// | Description : Five-stage RV32I pipeline (IF/ID/EX/MEM/WB) with optional  |
// |               EX bypassing, load-use interlock, branch/jump resolution   |
// |               in EX with flush, and a retire trace port.                 |
// | Ports       : clk, reset_n (async, active low)                           |
// |               instr_addr/instr_data : combinational instruction fetch    |
// |               data_addr/wdata/rdata/we/re : combinational data memory    |
// |               retire_valid/pc/rd/wdata : one pulse per retired instr     |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module riscv_pipeline_fwd #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter bit                    FORWARDING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [DATA_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr_data,
    output logic [DATA_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_we,
    output logic                  data_re,
    output logic                  retire_valid,
    output logic [DATA_WIDTH-1:0] retire_pc,
    output logic [4:0]            retire_rd,
    output logic [DATA_WIDTH-1:0] retire_wdata
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [DATA_WIDTH-1:0] c_FOUR = DATA_WIDTH'(4);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("riscv_pipeline_fwd: DATA_WIDTH must be 32");
        end
    endgenerate

    // ---------------- pipeline state ----------------
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_ifid_valid;
    logic [DATA_WIDTH-1:0] r_ifid_pc, r_ifid_instr;

    logic                  r_idex_valid, r_idex_reg_write, r_idex_use_imm, r_idex_is_op, r_idex_f7b5;
    logic                  r_idex_load, r_idex_store, r_idex_branch, r_idex_jal, r_idex_jalr;
    logic                  r_idex_lui, r_idex_auipc;
    logic [2:0]            r_idex_funct3;
    logic [4:0]            r_idex_rd, r_idex_rs1, r_idex_rs2;
    logic [DATA_WIDTH-1:0] r_idex_pc, r_idex_imm, r_idex_rs1_val, r_idex_rs2_val;

    logic                  r_exmem_valid, r_exmem_reg_write, r_exmem_load, r_exmem_store;
    logic [4:0]            r_exmem_rd;
    logic [DATA_WIDTH-1:0] r_exmem_pc, r_exmem_result, r_exmem_store_data;

    logic                  r_memwb_valid, r_memwb_reg_write;
    logic [4:0]            r_memwb_rd;
    logic [DATA_WIDTH-1:0] r_memwb_pc, r_memwb_wdata;

    logic [DATA_WIDTH-1:0] r_regs [32];

    // ---------------- decode (ID) ----------------
    logic [6:0]            w_opcode;
    logic [4:0]            w_rd, w_rs1, w_rs2;
    logic [2:0]            w_funct3;
    logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [DATA_WIDTH-1:0] w_dec_imm;
    logic w_dec_use_rs1, w_dec_use_rs2, w_dec_wr, w_dec_use_imm, w_dec_is_op;
    logic w_dec_load, w_dec_store, w_dec_branch, w_dec_jal, w_dec_jalr, w_dec_lui, w_dec_auipc;
    logic w_dec_reg_write;

    assign w_opcode = r_ifid_instr[6:0];
    assign w_rd     = r_ifid_instr[11:7];
    assign w_funct3 = r_ifid_instr[14:12];
    assign w_rs1    = r_ifid_instr[19:15];
    assign w_rs2    = r_ifid_instr[24:20];
    assign w_imm_i  = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
    assign w_imm_s  = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
    assign w_imm_b  = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                       r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
    assign w_imm_u  = {r_ifid_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[19:12],
                       r_ifid_instr[20], r_ifid_instr[30:21], 1'b0};

    always_comb begin
        w_dec_imm     = '0;
        w_dec_use_rs1 = 1'b0;
        w_dec_use_rs2 = 1'b0;
        w_dec_wr      = 1'b0;
        w_dec_use_imm = 1'b0;
        w_dec_is_op   = 1'b0;
        w_dec_load    = 1'b0;
        w_dec_store   = 1'b0;
        w_dec_branch  = 1'b0;
        w_dec_jal     = 1'b0;
        w_dec_jalr    = 1'b0;
        w_dec_lui     = 1'b0;
        w_dec_auipc   = 1'b0;
        case (w_opcode)
            c_OPC_OP:     begin w_dec_use_rs1 = 1'b1; w_dec_use_rs2 = 1'b1; w_dec_wr = 1'b1; w_dec_is_op = 1'b1; end
            c_OPC_IMM:    begin w_dec_use_rs1 = 1'b1; w_dec_wr = 1'b1; w_dec_use_imm = 1'b1; w_dec_imm = w_imm_i; end
            c_OPC_LUI:    begin w_dec_wr = 1'b1; w_dec_lui = 1'b1; w_dec_imm = w_imm_u; end
            c_OPC_AUIPC:  begin w_dec_wr = 1'b1; w_dec_auipc = 1'b1; w_dec_imm = w_imm_u; end
            c_OPC_LOAD:   begin w_dec_use_rs1 = 1'b1; w_dec_wr = 1'b1; w_dec_load = 1'b1; w_dec_imm = w_imm_i; end
            c_OPC_STORE:  begin w_dec_use_rs1 = 1'b1; w_dec_use_rs2 = 1'b1; w_dec_store = 1'b1; w_dec_imm = w_imm_s; end
            c_OPC_BRANCH: begin w_dec_use_rs1 = 1'b1; w_dec_use_rs2 = 1'b1; w_dec_branch = 1'b1; w_dec_imm = w_imm_b; end
            c_OPC_JAL:    begin w_dec_wr = 1'b1; w_dec_jal = 1'b1; w_dec_imm = w_imm_j; end
            c_OPC_JALR:   begin w_dec_use_rs1 = 1'b1; w_dec_wr = 1'b1; w_dec_jalr = 1'b1; w_dec_imm = w_imm_i; end
            default:      ;
        endcase
    end

    // x0 destinations are folded into "no write" here so every later stage,
    // the bypass network and the trace port see a single qualified flag.
    assign w_dec_reg_write = w_dec_wr & (w_rd != 5'd0);

    // Write-first register read: the instruction in WB is visible to ID.
    logic                  w_wb_we;
    logic [DATA_WIDTH-1:0] w_rs1_val, w_rs2_val;
    assign w_wb_we = r_memwb_valid & r_memwb_reg_write;

    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0)
            w_rs1_val = (w_wb_we && r_memwb_rd == w_rs1) ? r_memwb_wdata : r_regs[w_rs1];
        if (w_rs2 != 5'd0)
            w_rs2_val = (w_wb_we && r_memwb_rd == w_rs2) ? r_memwb_wdata : r_regs[w_rs2];
    end

    // ---------------- hazards and EX operand selection ----------------
    logic                  w_stall;
    logic [DATA_WIDTH-1:0] w_ex_rs1, w_ex_rs2;
    logic                  w_hit_ex, w_hit_mem;

    assign w_hit_ex  = r_idex_valid & r_idex_reg_write &
                       ((w_dec_use_rs1 & (w_rs1 == r_idex_rd)) | (w_dec_use_rs2 & (w_rs2 == r_idex_rd)));
    assign w_hit_mem = r_exmem_valid & r_exmem_reg_write &
                       ((w_dec_use_rs1 & (w_rs1 == r_exmem_rd)) | (w_dec_use_rs2 & (w_rs2 == r_exmem_rd)));

    generate
        if (FORWARDING) begin : g_fwd
            logic w_fwd_mem_ok, w_fwd_wb_ok;
            // A load's EX/MEM result is its address, never its data; the
            // load-use stall guarantees a consumer never needs it from there.
            assign w_fwd_mem_ok = r_exmem_valid & r_exmem_reg_write & ~r_exmem_load;
            assign w_fwd_wb_ok  = w_wb_we;
            assign w_stall  = r_ifid_valid & w_hit_ex & r_idex_load;
            assign w_ex_rs1 = (w_fwd_mem_ok && r_exmem_rd == r_idex_rs1) ? r_exmem_result :
                              (w_fwd_wb_ok  && r_memwb_rd == r_idex_rs1) ? r_memwb_wdata  : r_idex_rs1_val;
            assign w_ex_rs2 = (w_fwd_mem_ok && r_exmem_rd == r_idex_rs2) ? r_exmem_result :
                              (w_fwd_wb_ok  && r_memwb_rd == r_idex_rs2) ? r_memwb_wdata  : r_idex_rs2_val;
        end else begin : g_interlock
            // Hold in ID until the producer reaches WB, where the write-first
            // read path supplies the value.
            assign w_stall  = r_ifid_valid & (w_hit_ex | w_hit_mem);
            assign w_ex_rs1 = r_idex_rs1_val;
            assign w_ex_rs2 = r_idex_rs2_val;
        end
    endgenerate

    // ---------------- execute ----------------
    logic [DATA_WIDTH-1:0] w_ex_b, w_alu, w_pc_imm, w_rs1_imm, w_target, w_ex_result;
    logic                  w_taken, w_redirect;

    assign w_ex_b    = r_idex_use_imm ? r_idex_imm : w_ex_rs2;
    assign w_pc_imm  = r_idex_pc + r_idex_imm;
    assign w_rs1_imm = w_ex_rs1 + r_idex_imm;

    always_comb begin
        w_alu = '0;
        case (r_idex_funct3)
            3'b000:  w_alu = (r_idex_is_op && r_idex_f7b5) ? w_ex_rs1 - w_ex_b : w_ex_rs1 + w_ex_b;
            3'b001:  w_alu = w_ex_rs1 << w_ex_b[4:0];
            3'b010:  w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(w_ex_rs1) < $signed(w_ex_b)};
            3'b011:  w_alu = {{(DATA_WIDTH-1){1'b0}}, w_ex_rs1 < w_ex_b};
            3'b100:  w_alu = w_ex_rs1 ^ w_ex_b;
            3'b101:  w_alu = r_idex_f7b5 ? $unsigned($signed(w_ex_rs1) >>> w_ex_b[4:0])
                                         : w_ex_rs1 >> w_ex_b[4:0];
            3'b110:  w_alu = w_ex_rs1 | w_ex_b;
            default: w_alu = w_ex_rs1 & w_ex_b;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_idex_funct3)
            3'b000:  w_taken = (w_ex_rs1 == w_ex_rs2);
            3'b001:  w_taken = (w_ex_rs1 != w_ex_rs2);
            3'b100:  w_taken = ($signed(w_ex_rs1) <  $signed(w_ex_rs2));
            3'b101:  w_taken = ($signed(w_ex_rs1) >= $signed(w_ex_rs2));
            3'b110:  w_taken = (w_ex_rs1 <  w_ex_rs2);
            3'b111:  w_taken = (w_ex_rs1 >= w_ex_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_redirect = r_idex_valid & (r_idex_jal | r_idex_jalr | (r_idex_branch & w_taken));
    assign w_target   = r_idex_jalr ? {w_rs1_imm[DATA_WIDTH-1:1], 1'b0} : w_pc_imm;

    // Final writeback value for everything except loads; memory ops carry
    // their address in the same field.
    always_comb begin
        w_ex_result = w_alu;
        if (r_idex_lui)                      w_ex_result = r_idex_imm;
        else if (r_idex_auipc)               w_ex_result = w_pc_imm;
        else if (r_idex_jal || r_idex_jalr)  w_ex_result = r_idex_pc + c_FOUR;
        else if (r_idex_load || r_idex_store) w_ex_result = w_rs1_imm;
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc              <= RESET_PC;
            r_ifid_valid      <= 1'b0;
            r_ifid_pc         <= '0;
            r_ifid_instr      <= '0;
            r_idex_valid      <= 1'b0;
            r_idex_reg_write  <= 1'b0;
            r_idex_use_imm    <= 1'b0;
            r_idex_is_op      <= 1'b0;
            r_idex_f7b5       <= 1'b0;
            r_idex_load       <= 1'b0;
            r_idex_store      <= 1'b0;
            r_idex_branch     <= 1'b0;
            r_idex_jal        <= 1'b0;
            r_idex_jalr       <= 1'b0;
            r_idex_lui        <= 1'b0;
            r_idex_auipc      <= 1'b0;
            r_idex_funct3     <= '0;
            r_idex_rd         <= '0;
            r_idex_rs1        <= '0;
            r_idex_rs2        <= '0;
            r_idex_pc         <= '0;
            r_idex_imm        <= '0;
            r_idex_rs1_val    <= '0;
            r_idex_rs2_val    <= '0;
            r_exmem_valid     <= 1'b0;
            r_exmem_reg_write <= 1'b0;
            r_exmem_load      <= 1'b0;
            r_exmem_store     <= 1'b0;
            r_exmem_rd        <= '0;
            r_exmem_pc        <= '0;
            r_exmem_result    <= '0;
            r_exmem_store_data <= '0;
            r_memwb_valid     <= 1'b0;
            r_memwb_reg_write <= 1'b0;
            r_memwb_rd        <= '0;
            r_memwb_pc        <= '0;
            r_memwb_wdata     <= '0;
        end else begin
            // Redirect outranks stall: the stalled instruction is flushed anyway.
            if (w_redirect)    r_pc <= w_target;
            else if (!w_stall) r_pc <= r_pc + c_FOUR;

            if (w_redirect) begin
                r_ifid_valid <= 1'b0;
            end else if (!w_stall) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= r_pc;
                r_ifid_instr <= instr_data;
            end

            r_idex_valid     <= r_ifid_valid & ~w_stall & ~w_redirect;
            r_idex_reg_write <= w_dec_reg_write;
            r_idex_use_imm   <= w_dec_use_imm;
            r_idex_is_op     <= w_dec_is_op;
            r_idex_f7b5      <= r_ifid_instr[30];
            r_idex_load      <= w_dec_load;
            r_idex_store     <= w_dec_store;
            r_idex_branch    <= w_dec_branch;
            r_idex_jal       <= w_dec_jal;
            r_idex_jalr      <= w_dec_jalr;
            r_idex_lui       <= w_dec_lui;
            r_idex_auipc     <= w_dec_auipc;
            r_idex_funct3    <= w_funct3;
            r_idex_rd        <= w_rd;
            r_idex_rs1       <= w_rs1;
            r_idex_rs2       <= w_rs2;
            r_idex_pc        <= r_ifid_pc;
            r_idex_imm       <= w_dec_imm;
            r_idex_rs1_val   <= w_rs1_val;
            r_idex_rs2_val   <= w_rs2_val;

            r_exmem_valid      <= r_idex_valid;
            r_exmem_reg_write  <= r_idex_reg_write;
            r_exmem_load       <= r_idex_load;
            r_exmem_store      <= r_idex_store;
            r_exmem_rd         <= r_idex_rd;
            r_exmem_pc         <= r_idex_pc;
            r_exmem_result     <= w_ex_result;
            r_exmem_store_data <= w_ex_rs2;

            r_memwb_valid     <= r_exmem_valid;
            r_memwb_reg_write <= r_exmem_reg_write;
            r_memwb_rd        <= r_exmem_rd;
            r_memwb_pc        <= r_exmem_pc;
            r_memwb_wdata     <= r_exmem_load ? data_rdata : r_exmem_result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_wb_we) begin
            r_regs[r_memwb_rd] <= r_memwb_wdata;
        end
    end

    // ---------------- outputs ----------------
    assign instr_addr   = r_pc;
    assign data_addr    = {r_exmem_result[DATA_WIDTH-1:2], 2'b00};
    assign data_wdata   = r_exmem_store_data;
    assign data_we      = r_exmem_valid & r_exmem_store;
    assign data_re      = r_exmem_valid & r_exmem_load;
    assign retire_valid = r_memwb_valid;
    assign retire_pc    = r_memwb_valid ? r_memwb_pc : '0;
    assign retire_rd    = w_wb_we ? r_memwb_rd : 5'd0;
    assign retire_wdata = w_wb_we ? r_memwb_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_pipeline_fwd.sv
`default_nettype none
// ============================================================================
// | Module      : tb_riscv_pipeline_fwd                                      |
// | Description : Directed bench for riscv_pipeline_fwd; one instance with   |
// |               bypassing and one interlock-only, sharing an instruction   |
// |               image, each with its own data memory.                      |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_riscv_pipeline_fwd;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [31:0] instr_addr0, instr_data0, data_addr0, data_wdata0, data_rdata0, retire_pc0, retire_wdata0;
    logic [31:0] instr_addr1, instr_data1, data_addr1, data_wdata1, data_rdata1, retire_pc1, retire_wdata1;
    logic        data_we0, data_re0, retire_valid0, data_we1, data_re1, retire_valid1;
    logic [4:0]  retire_rd0, retire_rd1;

    logic [31:0] imem  [64];
    logic [31:0] dmem0 [64];
    logic [31:0] dmem1 [64];

    assign instr_data0 = (instr_addr0 < 32'h100) ? imem[instr_addr0[7:2]] : c_NOP;
    assign instr_data1 = (instr_addr1 < 32'h100) ? imem[instr_addr1[7:2]] : c_NOP;
    assign data_rdata0 = dmem0[data_addr0[7:2]];
    assign data_rdata1 = dmem1[data_addr1[7:2]];

    riscv_pipeline_fwd #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FORWARDING(1'b1)) u_dut_fwd (
        .clk(clk), .reset_n(reset_n),
        .instr_addr(instr_addr0), .instr_data(instr_data0),
        .data_addr(data_addr0), .data_wdata(data_wdata0), .data_rdata(data_rdata0),
        .data_we(data_we0), .data_re(data_re0),
        .retire_valid(retire_valid0), .retire_pc(retire_pc0),
        .retire_rd(retire_rd0), .retire_wdata(retire_wdata0)
    );

    riscv_pipeline_fwd #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FORWARDING(1'b0)) u_dut_ilk (
        .clk(clk), .reset_n(reset_n),
        .instr_addr(instr_addr1), .instr_data(instr_data1),
        .data_addr(data_addr1), .data_wdata(data_wdata1), .data_rdata(data_rdata1),
        .data_we(data_we1), .data_re(data_re1),
        .retire_valid(retire_valid1), .retire_pc(retire_pc1),
        .retire_rd(retire_rd1), .retire_wdata(retire_wdata1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Retire trace and fetch log, cycle index = rising edges since release.
    int          cyc;
    int          nre0;
    int          rn [2];
    logic [31:0] addr_log [64];
    logic [31:0] rl_pc [2][64];
    logic [31:0] rl_rd [2][64];
    logic [31:0] rl_wd [2][64];
    logic [31:0] rl_cyc [2][64];

    // Program 1: dependent ALU chain, then load-use.
    logic [31:0] t1_pc  [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] t1_rd  [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic [31:0] t1_wd  [5] = '{32'd5, 32'd8, 32'd13, 32'h1234, 32'h1235};
    logic [31:0] t1_cf  [5] = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd9};
    logic [31:0] t1_ci  [5] = '{32'd4, 32'd7, 32'd10, 32'd11, 32'd14};
    // Program 2: branches and jumps.
    logic [31:0] t2_pc  [12] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h1C, 32'h20,
                                 32'h30, 32'h24, 32'h28, 32'h2C};
    logic [31:0] t2_rd  [12] = '{32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1,
                                 32'd0, 32'd0, 32'd0, 32'd7};
    logic [31:0] t2_wd  [12] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h24,
                                 32'd0, 32'd0, 32'd0, 32'd1};
    logic [31:0] t2_cy  [12] = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd11, 32'd12, 32'd13,
                                 32'd16, 32'd19, 32'd20, 32'd21};

    task automatic load_program(input int prog);
        for (int i = 0; i < 64; i++) begin
            imem[i]  = c_NOP;
            dmem0[i] = 32'h0;
            dmem1[i] = 32'h0;
        end
        dmem0[0] = 32'hDEAD_BEEF;  dmem1[0] = 32'hDEAD_BEEF;
        dmem0[16] = 32'h0000_1234; dmem1[16] = 32'h0000_1234;
        case (prog)
            1: begin
                imem[0] = 32'h0050_0093; // addi x1,x0,5
                imem[1] = 32'h0030_8113; // addi x2,x1,3
                imem[2] = 32'h0011_01B3; // add  x3,x2,x1
                imem[3] = 32'h0400_2203; // lw   x4,0x40(x0)
                imem[4] = 32'h0012_0293; // addi x5,x4,1
            end
            2: begin
                imem[0]  = 32'h0020_8433; // add  x8,x1,x2 (regs cleared by reset)
                imem[4]  = 32'h0000_0463; // beq  x0,x0,+8
                imem[5]  = 32'h0010_0313; // addi x6,x0,1 (squashed)
                imem[6]  = 32'h0000_1463; // bne  x0,x0,+8
                imem[8]  = 32'h0100_00EF; // jal  x1,+16
                imem[9]  = 32'h0070_0013; // addi x0,x0,7
                imem[11] = 32'h0010_0393; // addi x7,x0,1
                imem[12] = 32'h0000_8067; // jalr x0,0(x1)
            end
            3: begin
                imem[0] = 32'h0050_0093; // addi x1,x0,5
                imem[1] = 32'h0010_2023; // sw   x1,0(x0)
            end
            default: ;
        endcase
    endtask

    task automatic clear_logs();
        cyc    = 0;
        nre0   = 0;
        rn[0]  = 0;
        rn[1]  = 0;
        for (int i = 0; i < 64; i++) begin
            addr_log[i] = 'x;
            for (int d = 0; d < 2; d++) begin
                rl_pc[d][i] = 'x; rl_rd[d][i] = 'x; rl_wd[d][i] = 'x; rl_cyc[d][i] = 'x;
            end
        end
    endtask

    task automatic sample();
        if (cyc < 64) addr_log[cyc] = instr_addr0;
        if (data_re0) nre0++;
        if (retire_valid0 && rn[0] < 64) begin
            rl_pc[0][rn[0]] = retire_pc0; rl_rd[0][rn[0]] = {27'b0, retire_rd0};
            rl_wd[0][rn[0]] = retire_wdata0; rl_cyc[0][rn[0]] = cyc;
            rn[0]++;
        end
        if (retire_valid1 && rn[1] < 64) begin
            rl_pc[1][rn[1]] = retire_pc1; rl_rd[1][rn[1]] = {27'b0, retire_rd1};
            rl_wd[1][rn[1]] = retire_wdata1; rl_cyc[1][rn[1]] = cyc;
            rn[1]++;
        end
    endtask

    // Stores commit at the rising edge, exactly as a synchronous RAM would.
    task automatic tick();
        @(posedge clk);
        if (data_we0) dmem0[data_addr0[7:2]] = data_wdata0;
        if (data_we1) dmem1[data_addr1[7:2]] = data_wdata1;
        @(negedge clk);
        cyc++;
        sample();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input int prog);
        reset_n = 1'b0;
        load_program(prog);
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_instr_addr",   instr_addr0, 32'h0);
        check_value("rst_instr_addr_i", instr_addr1, 32'h0);
        check_value("rst_data_we",      {31'b0, data_we0}, 32'h0);
        check_value("rst_data_re",      {31'b0, data_re0}, 32'h0);
        check_value("rst_retire_valid", {31'b0, retire_valid0}, 32'h0);
        check_value("rst_retire_pc",    retire_pc0, 32'h0);
        check_value("rst_retire_rd",    {27'b0, retire_rd0}, 32'h0);
        check_value("rst_retire_wdata", retire_wdata0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        #1;
        sample();
    endtask

    task automatic check_retire(input string tag, input int d, input int k,
                                input logic [31:0] pc, input logic [31:0] rd,
                                input logic [31:0] wd, input logic [31:0] c);
        check_value($sformatf("%s%0d_pc", tag, k),  rl_pc[d][k],  pc);
        check_value($sformatf("%s%0d_rd", tag, k),  rl_rd[d][k],  rd);
        check_value($sformatf("%s%0d_wd", tag, k),  rl_wd[d][k],  wd);
        check_value($sformatf("%s%0d_cyc", tag, k), rl_cyc[d][k], c);
    endtask

    initial begin
        reset_n = 1'b0;
        clear_logs();

        // NOP stream: one fetch per cycle, first retire after four edges.
        start(0);
        run(8);
        for (int k = 0; k < 4; k++)
            check_value($sformatf("nop_fetch%0d", k), addr_log[k], 32'(4 * k));
        check_retire("nop_ret", 0, 0, 32'h0, 32'h0, 32'h0, 32'd4);
        check_value("nop_retire_count", rn[0], 32'd5);

        // ALU chain and load-use, both forwarding modes.
        start(1);
        run(18);
        for (int k = 0; k < 5; k++) begin
            check_retire("fwd_ret", 0, k, t1_pc[k], t1_rd[k], t1_wd[k], t1_cf[k]);
            check_retire("ilk_ret", 1, k, t1_pc[k], t1_rd[k], t1_wd[k], t1_ci[k]);
        end
        check_value("lw_data_re_pulses", nre0, 32'd1);

        // Branch / jump flushes; x0 writes report rd 0.
        start(2);
        run(24);
        check_value("beq_shadow_fetched", addr_log[5], 32'h14);
        for (int k = 0; k < 12; k++) begin
            check_retire("ctl_fwd", 0, k, t2_pc[k], t2_rd[k], t2_wd[k], t2_cy[k]);
            check_retire("ctl_ilk", 1, k, t2_pc[k], t2_rd[k], t2_wd[k], t2_cy[k]);
        end

        // Reset while a store sits in MEM.
        start(3);
        run(4);
        check_value("sw_we_in_mem", {31'b0, data_we0}, 32'h1);
        check_value("sw_addr",      data_addr0, 32'h0);
        check_value("sw_wdata",     data_wdata0, 32'h5);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("kill_data_we",      {31'b0, data_we0}, 32'h0);
        check_value("kill_instr_addr",   instr_addr0, 32'h0);
        check_value("kill_retire_valid", {31'b0, retire_valid0}, 32'h0);
        tick();
        check_value("kill_no_store", dmem0[0], 32'hDEAD_BEEF);
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        #1;
        sample();
        run(2);
        for (int k = 0; k < 3; k++)
            check_value($sformatf("restart_fetch%0d", k), addr_log[k], 32'(4 * k));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
